// File: rtl/spi_master_param.sv
// Parametrised SPI master (CPOL/CPHA, bit order, word width, NUM_SS selects); rx_valid lands
// (2*DATA_WIDTH+2)*CLK_DIV+1 cycles after acceptance; tx_ready is low for the whole transfer.
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int NUM_SS     = 1,
  parameter int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [SS_W-1:0]       ss_idx,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sclk,
  output logic [NUM_SS-1:0]     ss_n,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state, state_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic [SS_W-1:0]       ss_q;
  logic                  cpol_q, cpha_q, lsb_q, sclk_q;
  logic                  accept, half_done, edge_tick, leading, shift_en, sample_en;

  assign tx_ready  = (state == IDLE);
  assign busy      = !tx_ready;
  assign accept    = tx_valid && tx_ready;
  assign half_done = (div_cnt == DIV_LAST);
  assign edge_tick = (state == XFER) && half_done;
  // edge_cnt counts completed SCLK edges, so an even count means the next edge is leading
  assign leading   = !edge_cnt[0];
  assign shift_en  = edge_tick && (cpha_q ? (leading && (edge_cnt != '0))
                                          : (!leading && (edge_cnt != EDGE_LAST)));
  assign sample_en = edge_tick && (cpha_q ? !leading : leading);
  assign sclk      = sclk_q;
  assign mosi      = busy ? (lsb_q ? tx_sr[0] : tx_sr[DATA_WIDTH-1]) : 1'b0;

  always_comb begin
    ss_n = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (busy && (ss_q == SS_W'(i))) ss_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (half_done) state_nxt = XFER;
      XFER:    if (half_done && (edge_cnt == EDGE_LAST)) state_nxt = HOLD;
      HOLD:    if (half_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      ss_q     <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      sclk_q   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE) begin
        sclk_q   <= cpol;
        div_cnt  <= '0;
        edge_cnt <= '0;
        if (accept) begin
          tx_sr  <= tx_data;
          ss_q   <= ss_idx;
          cpol_q <= cpol;
          cpha_q <= cpha;
          lsb_q  <= lsb_first;
        end
      end else begin
        div_cnt <= half_done ? '0 : div_cnt + 1'b1;
        if (edge_tick) begin
          sclk_q   <= !sclk_q;
          edge_cnt <= edge_cnt + 1'b1;
        end
        if (shift_en) tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
        if (sample_en) begin
          rx_sr <= lsb_q ? {miso, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], miso};
        end
        if ((state == HOLD) && half_done) begin
          rx_data  <= rx_sr;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: two instances (8-bit/div 2/3 selects and 12-bit/div 3), a word-level
// SPI slave model, and queue-based scoreboards popped whenever rx_valid strobes.
module tb_spi_master_param;
  localparam int DW = 8, CD = 2, NSS = 3;
  localparam int DWB = 12, CDB = 3;

  typedef struct {
    logic [31:0] rx;
    logic [31:0] tx;
    int          cyc;
    logic        cpol;
    logic        slv;
    logic        last;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]  tx_data = '0, rx_data;
  logic           tx_valid = 1'b0, tx_ready, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [1:0]     ss_idx = '0;
  logic           miso, mosi, sclk, rx_valid, busy;
  logic [NSS-1:0] ss_n;

  logic [DWB-1:0] tx_data_b = '0, rx_data_b;
  logic           tx_valid_b = 1'b0, tx_ready_b, cpol_b = 1'b0, cpha_b = 1'b0, lsb_b = 1'b0;
  logic [0:0]     ss_idx_b = '0, ss_n_b;
  logic           miso_b, mosi_b, sclk_b, rx_valid_b, busy_b;

  spi_master_param #(.DATA_WIDTH(DW), .CLK_DIV(CD), .NUM_SS(NSS)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ss_idx(ss_idx), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso),
    .mosi(mosi), .sclk(sclk), .ss_n(ss_n), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy));

  spi_master_param #(.DATA_WIDTH(DWB), .CLK_DIV(CDB), .NUM_SS(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .ss_idx(ss_idx_b), .cpol(cpol_b), .cpha(cpha_b), .lsb_first(lsb_b), .miso(miso_b),
    .mosi(mosi_b), .sclk(sclk_b), .ss_n(ss_n_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .busy(busy_b));

  exp_t q_a[$], q_b[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, want, $time);
    end
  endtask

  // Slave model: bit n of the word travels on the n-th sampling edge of the transfer.
  logic          cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0, cur_loop = 1'b1;
  logic [DW-1:0] resp = '0, srx = '0;
  int            sn = 0, sedges = 0;
  logic          prev_sclk = 1'b0, prev_mosi = 1'b0, prev_idle = 1'b1;

  always_comb begin
    miso = cur_loop ? mosi : 1'b0;
    if (!cur_loop && sn < DW) miso = resp[cur_lsb ? sn : DW - 1 - sn];
  end
  assign miso_b = mosi_b;

  always @(negedge clk) begin
    if (prev_idle && !(&ss_n)) begin
      sn = 0; sedges = 0; srx = '0;
    end else if (!(&ss_n) && sclk != prev_sclk) begin
      sedges++;
      if (((prev_sclk == cur_cpol) != cur_cpha) && sn < DW) begin
        srx[cur_lsb ? sn : DW - 1 - sn] = prev_mosi;
        sn++;
      end
    end
    prev_sclk = sclk; prev_mosi = mosi; prev_idle = &ss_n;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rx_valid) begin
      if (q_a.size() == 0) chk("a_unexpected_rx_valid", 32'(rx_valid), 0);
      else begin
        e = q_a.pop_front();
        chk("a_rx_data", 32'(rx_data), e.rx);
        chk("a_rx_cycle", cyc, e.cyc);
        chk("a_sclk_end", 32'(sclk), 32'(e.cpol));
        chk("a_ss_release", 32'(ss_n), 32'h7);
        chk("a_ready_at_done", 32'(tx_ready), 1);
        if (e.slv) begin
          chk("a_slave_rx", 32'(srx), e.tx);
          chk("a_sclk_edges", sedges, 2 * DW);
        end
      end
    end
  end

  logic last_mosi_b = 1'b0;
  always @(negedge clk) if (busy_b) last_mosi_b <= mosi_b;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rx_valid_b) begin
      if (q_b.size() == 0) chk("b_unexpected_rx_valid", 32'(rx_valid_b), 0);
      else begin
        e = q_b.pop_front();
        chk("b_rx_data", 32'(rx_data_b), e.rx);
        chk("b_rx_cycle", cyc, e.cyc);
        chk("b_sclk_end", 32'(sclk_b), 32'(e.cpol));
        chk("b_last_mosi", 32'(last_mosi_b), 32'(e.last));
      end
    end
  end

  task automatic wait_idle_a();
    int t = 0;
    while (!tx_ready && t < 200) begin @(negedge clk); t++; end
    chk("a_idle_wait", 32'(tx_ready), 1);
  endtask

  task automatic send_a(input logic [DW-1:0] d, input logic [1:0] idx, input logic pol,
                        input logic pha, input logic lsb, input logic loop,
                        input logic [DW-1:0] rsp, input bit push);
    exp_t e;
    logic [NSS-1:0] want;
    wait_idle_a();
    cpol = pol; cpha = pha; lsb_first = lsb;
    @(negedge clk); @(negedge clk);
    chk("a_sclk_idle", 32'(sclk), 32'(pol));
    cur_cpol = pol; cur_cpha = pha; cur_lsb = lsb; cur_loop = loop; resp = rsp;
    tx_data = d; ss_idx = idx; tx_valid = 1'b1;
    e.rx = loop ? 32'(d) : 32'(rsp); e.tx = 32'(d); e.cpol = pol;
    e.cyc = cyc + 1 + (2 * DW + 2) * CD; e.slv = (idx < NSS); e.last = 1'b0;
    if (push) q_a.push_back(e);
    @(negedge clk);
    tx_valid = 1'b0;
    want = '1;
    if (idx < NSS) want[idx] = 1'b0;
    chk("a_busy_start", 32'(busy), 1);
    chk("a_ready_start", 32'(tx_ready), 0);
    chk("a_ss_select", 32'(ss_n), 32'(want));
    // Mode and select inputs wander during the transfer and must be ignored.
    tx_data = DW'($urandom); ss_idx = 2'($urandom);
    cpol = 1'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom);
  endtask

  task automatic send_b(input logic [DWB-1:0] d, input logic pol, input logic pha,
                        input logic lsb);
    exp_t e;
    int t = 0;
    while (!tx_ready_b && t < 300) begin @(negedge clk); t++; end
    chk("b_idle_wait", 32'(tx_ready_b), 1);
    cpol_b = pol; cpha_b = pha; lsb_b = lsb;
    @(negedge clk); @(negedge clk);
    chk("b_sclk_idle", 32'(sclk_b), 32'(pol));
    tx_data_b = d; tx_valid_b = 1'b1;
    e.rx = 32'(d); e.tx = 32'(d); e.cpol = pol; e.slv = 1'b0;
    e.cyc = cyc + 1 + (2 * DWB + 2) * CDB;
    e.last = lsb ? d[DWB-1] : d[0];
    q_b.push_back(e);
    @(negedge clk);
    tx_valid_b = 1'b0;
    chk("b_first_mosi", 32'(mosi_b), 32'(lsb ? d[0] : d[DWB-1]));
    chk("b_ss_select", 32'(ss_n_b), 0);
    cpol_b = 1'($urandom); cpha_b = 1'($urandom); lsb_b = 1'($urandom);
  endtask

  initial begin
    exp_t e;
    int t;
    logic [1:0] idx;
    logic [NSS-1:0] pss;
    logic loop;
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ss_n", 32'(ss_n), 32'h7);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_b_rx_data", 32'(rx_data_b), 0);
    cpol = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    send_a(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    for (int m = 0; m < 8; m++) send_a(8'hC3, 2'd2, m[1], m[0], m[2], 1'b0, 8'h3C, 1'b1);
    send_a(8'h6E, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) begin
      idx  = 2'($urandom_range(0, 3));
      loop = (idx >= 2'(NSS)) ? 1'b1 : 1'($urandom);
      send_a(DW'($urandom), idx, 1'($urandom), 1'($urandom), 1'($urandom), loop,
             DW'($urandom), 1'b1);
    end

    // Back-to-back with tx_valid held high throughout.
    wait_idle_a();
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    @(negedge clk); @(negedge clk);
    cur_cpol = 1'b0; cur_cpha = 1'b0; cur_lsb = 1'b0; cur_loop = 1'b1;
    tx_data = 8'h11; ss_idx = 2'd1; tx_valid = 1'b1;
    e.rx = 32'h11; e.tx = 32'h11; e.cpol = 1'b0; e.slv = 1'b1; e.last = 1'b0;
    e.cyc = cyc + 1 + (2 * DW + 2) * CD;
    q_a.push_back(e);
    e.rx = 32'h22; e.tx = 32'h22; e.cyc = e.cyc + 1 + (2 * DW + 2) * CD;
    q_a.push_back(e);
    @(negedge clk);
    tx_data = 8'h22;
    chk("b2b_busy_first", 32'(busy), 1);
    t = 0; pss = ss_n;
    while (!rx_valid && t < 100) begin pss = ss_n; @(negedge clk); t++; end
    chk("b2b_rx_valid_seen", 32'(rx_valid), 1);
    chk("b2b_ss_before_gap", 32'(pss), 32'h5);
    chk("b2b_ss_gap", 32'(ss_n), 32'h7);
    chk("b2b_ready_in_gap", 32'(tx_ready), 1);
    @(negedge clk);
    chk("b2b_ss_after_gap", 32'(ss_n), 32'h5);
    chk("b2b_busy_second", 32'(busy), 1);
    tx_valid = 1'b0;

    // Abort after three bits; the aborted word must never report.
    send_a(8'hE7, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    cpol = 1'b1;
    repeat (CD + 12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ss_n", 32'(ss_n), 32'h7);
    chk("abort_sclk", 32'(sclk), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rx_valid", 32'(rx_valid), 0);
    chk("abort_rx_data", 32'(rx_data), 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    send_a(8'h5A, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'h96, 1'b1);

    send_b(12'h801, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_b(DWB'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < 500) begin @(negedge clk); t++; end
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
